// File: rtl/lock_entry_frontend.sv
// Input stage for the combination lock: synchronises ENTER and the switches, debounces
// the button and hands out one range-checked digit per press through a one-entry buffer.
module lock_entry_frontend #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_n,
    input  logic [9:0] sw,
    input  logic       digit_ready,
    output logic       digit_valid,
    output logic [3:0] digit,
    output logic       digit_err,
    output logic       overrun,
    output logic [2:0] entry_count
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic       key_p0, key_p1;
    logic [9:0] sw_p0, sw_p1;
    state_t     state;
    logic [CNT_W-1:0] cnt;
    logic       capture;
    logic       pop;
    logic [4:0] cap_word;

    // Values above 9 (any of the ten bits) are flagged and shown as 4'hF.
    function automatic logic [4:0] classify(input logic [9:0] v);
        if (v > 10'd9)
            return {1'b1, 4'hF};
        else
            return {1'b0, v[3:0]};
    endfunction

    function automatic logic [2:0] sat_inc(input logic [2:0] c);
        return (c == 3'd7) ? c : c + 3'd1;
    endfunction

    // Stage p0/p1: two-flop synchronisers, key resets to released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_p0 <= 1'b1;
            key_p1 <= 1'b1;
            sw_p0  <= '0;
            sw_p1  <= '0;
        end else begin
            key_p0 <= key_n;
            key_p1 <= key_p0;
            sw_p0  <= sw;
            sw_p1  <= sw_p0;
        end
    end

    assign capture  = (state == PRESS_WAIT) && !key_p1 && (cnt == CNT_LAST);
    assign pop      = digit_valid && digit_ready;
    assign cap_word = classify(sw_p1);

    // Debounce FSM on the synchronised key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!key_p1) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (key_p1)
                        state <= IDLE;
                    else if (cnt == CNT_LAST)
                        state <= PRESSED;
                    else
                        cnt <= cnt + 1'b1;
                end
                PRESSED: begin
                    if (key_p1) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (!key_p1)
                        state <= PRESSED;
                    else if (cnt == CNT_LAST)
                        state <= IDLE;
                    else
                        cnt <= cnt + 1'b1;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // One-entry buffer; a pop in the same cycle frees the slot for a new capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_valid <= 1'b0;
            digit       <= 4'd0;
            digit_err   <= 1'b0;
            overrun     <= 1'b0;
            entry_count <= 3'd0;
        end else begin
            if (capture && (!digit_valid || pop)) begin
                digit_valid <= 1'b1;
                digit       <= cap_word[3:0];
                digit_err   <= cap_word[4];
            end else if (capture) begin
                overrun <= 1'b1;
            end else if (pop) begin
                digit_valid <= 1'b0;
            end
            if (pop)
                entry_count <= sat_inc(entry_count);
        end
    end

endmodule

// File: tb/tb_lock_entry_frontend.sv
// Bench for lock_entry_frontend: directed scenarios plus random key/switch/ready traffic,
// compared every cycle against a run-length reference model of the debounced button.
module tb_lock_entry_frontend;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_n;
    logic [9:0] sw;
    logic       digit_ready;
    logic       digit_valid;
    logic [3:0] digit;
    logic       digit_err;
    logic       overrun;
    logic [2:0] entry_count;

    always #5 clk = ~clk;

    lock_entry_frontend #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .key_n(key_n),
        .sw(sw),
        .digit_ready(digit_ready),
        .digit_valid(digit_valid),
        .digit(digit),
        .digit_err(digit_err),
        .overrun(overrun),
        .entry_count(entry_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the debounced level flips once the synchronised key has disagreed
    // with it for D+1 consecutive samples; each flip to "pressed" yields one entry.
    bit       m_k1, m_k2;
    bit [9:0] m_w1, m_w2;
    bit       m_pressed;
    int       m_run;
    bit       m_valid;
    int       m_digit;
    bit       m_err;
    bit       m_ovr;
    int       m_cnt;

    task automatic model_reset();
        m_k1 = 1'b1; m_k2 = 1'b1; m_w1 = '0; m_w2 = '0;
        m_pressed = 1'b0; m_run = 0;
        m_valid = 1'b0; m_digit = 0; m_err = 1'b0; m_ovr = 1'b0; m_cnt = 0;
    endtask

    task automatic model_step();
        bit       seen_low;
        bit [9:0] seen_sw;
        bit       cap;
        bit       pop;
        if (rst) begin
            model_reset();
            return;
        end
        seen_low = !m_k2;
        seen_sw  = m_w2;
        m_k2 = m_k1; m_k1 = key_n;
        m_w2 = m_w1; m_w1 = sw;
        cap = 1'b0;
        if (seen_low != m_pressed) begin
            m_run++;
            if (m_run == D + 1) begin
                m_pressed = seen_low;
                m_run = 0;
                cap = seen_low;
            end
        end else begin
            m_run = 0;
        end
        pop = m_valid && digit_ready;
        if (cap && (!m_valid || pop)) begin
            m_valid = 1'b1;
            m_err   = (int'(seen_sw) >= 10);
            m_digit = m_err ? 15 : int'(seen_sw);
        end else if (cap) begin
            m_ovr = 1'b1;
        end else if (pop) begin
            m_valid = 1'b0;
        end
        if (pop && m_cnt < 7) m_cnt++;
    endtask

    task automatic compare_all();
        check("valid", digit_valid, m_valid);
        check("digit", digit, m_digit);
        check("err", digit_err, m_err);
        check("overrun", overrun, m_ovr);
        check("count", entry_count, m_cnt);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic press(input logic [9:0] v, input int hold, input int rel);
        sw = v;
        key_n = 1'b0;
        repeat (hold) cycle();
        key_n = 1'b1;
        repeat (rel) cycle();
    endtask

    task automatic pop_one();
        digit_ready = 1'b1;
        cycle();
        digit_ready = 1'b0;
    endtask

    task automatic async_reset(input int len);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        repeat (len) cycle();
        rst = 1'b0;
    endtask

    initial begin
        int seg;
        rst = 1'b1; key_n = 1'b1; sw = '0; digit_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        check("rst_valid", digit_valid, 0);
        check("rst_count", entry_count, 0);
        rst = 1'b0;
        cycle();

        // Clean press with exact latency.
        sw = 10'd7;
        key_n = 1'b0;
        repeat (6) cycle();
        check("lat_early", digit_valid, 0);
        cycle();
        check("lat_valid", digit_valid, 1);
        check("lat_digit", digit, 7);
        check("lat_err", digit_err, 0);
        repeat (3) cycle();
        pop_one();
        check("pop_valid", digit_valid, 0);
        check("pop_count", entry_count, 1);
        key_n = 1'b1;
        repeat (8) cycle();

        // Press bounce, then release bounce.
        sw = 10'd6;
        key_n = 1'b0; repeat (2) cycle();
        key_n = 1'b1; repeat (1) cycle();
        key_n = 1'b0; repeat (10) cycle();
        key_n = 1'b1; repeat (2) cycle();
        key_n = 1'b0; repeat (1) cycle();
        key_n = 1'b1; repeat (10) cycle();
        check("bounce_digit", digit, 6);
        check("bounce_ovr", overrun, 0);
        pop_one();

        // Range errors.
        press(10'd12, 8, 8);
        check("range12_digit", digit, 15);
        check("range12_err", digit_err, 1);
        pop_one();
        press(10'h200, 8, 8);
        check("range200_digit", digit, 15);
        check("range200_err", digit_err, 1);
        pop_one();

        // Overrun.
        press(10'd3, 8, 8);
        press(10'd5, 8, 8);
        check("ovr_digit", digit, 3);
        check("ovr_flag", overrun, 1);
        pop_one();
        check("ovr_popped", digit_valid, 0);
        check("ovr_sticky", overrun, 1);

        // Simultaneous pop and capture after a fresh reset.
        async_reset(2);
        cycle();
        press(10'd1, 8, 8);
        sw = 10'd2;
        key_n = 1'b0;
        repeat (6) cycle();
        digit_ready = 1'b1;
        cycle();
        digit_ready = 1'b0;
        check("simul_valid", digit_valid, 1);
        check("simul_digit", digit, 2);
        check("simul_ovr", overrun, 0);
        key_n = 1'b1;
        repeat (8) cycle();

        // Reset mid PRESS_WAIT with an entry pending; key held through reset.
        sw = 10'd4;
        key_n = 1'b0;
        repeat (4) cycle();
        async_reset(2);
        check("mid_rst_valid", digit_valid, 0);
        repeat (6) cycle();
        check("held_early", digit_valid, 0);
        cycle();
        check("held_valid", digit_valid, 1);
        check("held_digit", digit, 4);
        key_n = 1'b1;
        repeat (8) cycle();
        pop_one();
        for (int i = 0; i < 9; i++) begin
            press(10'(i), 7, 7);
            pop_one();
        end
        check("sat_count", entry_count, 7);

        // Random traffic.
        seg = 0;
        for (int i = 0; i < 1500; i++) begin
            if (seg == 0) begin
                key_n = ~key_n;
                seg = $urandom_range(1, 9);
            end
            seg--;
            sw = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 11)) : 10'($urandom);
            digit_ready = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 299) == 0);
            cycle();
            rst = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lock_entry_frontend.md
# lock_entry_frontend

Upstream input stage for the combination-lock state machine: converts the raw, bouncing ENTER push-button and the 10 slide switches into clean, one-at-a-time digit entries. Synchronises both inputs, debounces the button with a press/release state machine, captures and range-checks the switch value on each accepted press, and holds the result in a one-entry valid/ready buffer. The lock FSM consumes entries from this buffer in place of running directly off the button as a clock.

## Interface
- DEBOUNCE_CYCLES, 50000: stable cycles required to accept a press or release (1 ms at 50 MHz); legal range ≥2
- CNT_W, 16: debounce counter width; must hold DEBOUNCE_CYCLES-1
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- key_n  in  1  raw ENTER button, active-low, asynchronous to clk
- sw  in  10  raw slide switches, asynchronous to clk
- digit_ready  in  1  downstream accepts the buffered entry this cycle
- digit_valid  out  1  buffer holds an entry
- digit  out  4  entered digit 0–9; 4'hF when out of range
- digit_err  out  1  captured switch value was >9
- overrun  out  1  sticky: a press was dropped because the buffer was full
- entry_count  out  3  handshakes completed since reset, saturating at 7

## Operation
- Synchronisers: key_n and sw each pass through two flops; reset values key 1 (released), sw 0. All logic below uses synchronised values only.
- Debounce FSM states:
  - IDLE: button released and stable. Synchronised key low -> PRESS_WAIT, cnt=0.
  - PRESS_WAIT: key high -> IDLE. Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> PRESSED and issue a capture, else cnt+1.
  - PRESSED: key high -> RELEASE_WAIT, cnt=0.
  - RELEASE_WAIT: key low -> PRESSED with no new capture. If cnt==DEBOUNCE_CYCLES-1 -> IDLE, else cnt+1.
- Capture: the value is the synchronised sw at the capture edge.
  - sw ≤ 9: digit=sw[3:0], digit_err=0.
  - sw > 9 (any upper bit set): digit=4'hF, digit_err=1.
  - The comparison uses the full 10-bit value.
- One-entry buffer (per clock):
  - pop = digit_valid & digit_ready.
  - Capture while empty, or while a pop happens in the same cycle: load the new entry; digit_valid stays or becomes 1.
  - Capture while full with no pop: drop the entry, set overrun. The held entry is unchanged.
  - Pop with no capture: digit_valid -> 0. digit and digit_err hold their last values.
  - Each pop increments entry_count, saturating at 7.
- digit_ready while digit_valid=0 has no effect.
- Exactly one capture per debounced press, regardless of how long the button is held.

## Timing
- Reset values: digit_valid 0, digit 0, digit_err 0, overrun 0, entry_count 0, FSM IDLE, cnt 0.
- Reset asserted mid-operation: all of the above take effect immediately and asynchronously. Any pending entry is discarded. A button still held at reset release must pass the full PRESS_WAIT sequence again.
- Press latency: let edge k be the first clk edge that samples key_n low.
  - FSM enters PRESS_WAIT at edge k+2.
  - Capture occurs at edge k+DEBOUNCE_CYCLES+2 if key_n stays low throughout.
  - digit_valid is high after that edge.
- A low pulse on synchronised key shorter than DEBOUNCE_CYCLES cycles produces no capture.
- A release bounce shorter than DEBOUNCE_CYCLES cycles during RELEASE_WAIT returns to PRESSED with no capture.
- A pop is seen by the downstream on the same edge where digit_valid falls. A back-to-back capture-with-pop keeps digit_valid high continuously.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and digit_ready held 0 unless stated.
- Clean press: reset, sw=7, key_n low from edge k -> digit_valid=1 after edge k+6, digit=7, digit_err=0. Then ready=1 for one cycle -> valid=0, entry_count=1.
- Bounce: key_n low for 2 cycles, high for 1, then low steadily -> exactly one capture, 4 cycles after the last falling transition is synchronised. A release bounce -> no second entry.
- Range error: sw=10'd12 on press -> digit=4'hF, digit_err=1. Repeat with sw=10'h200 -> same.
- Overrun: press with sw=3, ready=0; release; press with sw=5 -> digit stays 3, overrun=1. Ready pulse -> valid=0; overrun stays 1.
- Simultaneous pop/capture: align ready=1 with the capture edge of a second press (sw=2) -> digit_valid stays 1, digit=2, entry_count+1, overrun=0.
- Reset mid-PRESS_WAIT and with entry pending: assert rst -> all outputs 0 immediately. Key held through release -> new capture 4 cycles after reset deasserts plus synchroniser delay. Nine handshakes -> entry_count=7.
